register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; NUM_REGS = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous request to restart the clear sweep.
REQ-006 SHALL have port we, input, 1 bit: write enable.
REQ-007 SHALL have port waddr, input, ADDR_WIDTH bits: write address.
REQ-008 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have ports raddr_a and raddr_b, inputs, ADDR_WIDTH bits each: read addresses.
REQ-010 SHALL have ports rdata_a and rdata_b, outputs, DATA_WIDTH bits each: read data.
REQ-011 SHALL have port busy, output, 1 bit: high while the clear sweep runs.

Function
REQ-012 SHALL implement a two-state FSM: CLEAR and READY.
REQ-013 In CLEAR, SHALL zero one register per cycle, indices 1 to NUM_REGS-1 ascending, driven by a sweep counter.
REQ-014 SHALL go CLEAR -> READY on the cycle after index NUM_REGS-1 is zeroed, so the sweep takes NUM_REGS-1 cycles after reset deasserts.
REQ-015 clear=1 in READY SHALL move the FSM to CLEAR with the counter at 1 on the next edge.
REQ-016 clear=1 in CLEAR SHALL restart the counter at 1.
REQ-017 busy SHALL be 1 exactly when state is CLEAR.
REQ-018 In READY, we=1 SHALL store wdata at waddr on posedge clk.
REQ-019 Writes to address 0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-020 Writes while busy=1 SHALL be discarded with no error indication.
REQ-021 Reads SHALL be combinational: rdata_x follows raddr_x and the register contents in the same cycle.
REQ-022 While busy=1, rdata_a and rdata_b SHALL read 0 for all addresses.
REQ-023 Both read ports SHALL be independent; raddr_a==raddr_b SHALL return identical data.
REQ-024 Simultaneous clear=1 and we=1 in READY: the write SHALL be discarded.

Reset
REQ-025 reset=1 at posedge clk SHALL set state CLEAR and counter 1; busy SHALL read 1 from the cycle after that edge.
REQ-026 reset SHALL take priority over clear and we.
REQ-027 reset asserted mid-sweep SHALL restart the sweep from index 1.
REQ-028 Register contents SHALL be unspecified after power-up until the first sweep completes; they SHALL be observable only through reads, which return 0 while busy.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, in READY, we=1 with waddr==raddr_x and waddr!=0 SHALL drive rdata_x = wdata in the same cycle.
REQ-031 Without REGFILE_BYPASS_EN, a written value SHALL become visible on read only in the cycle after the write edge.

Structure
REQ-032 Shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default width constants.
REQ-033 The sweep FSM and counter SHALL be a sub-module named regfile_clear_seq, outputting busy, the clear index and the clear strobe.

Verification
REQ-034 Reset held 2 cycles, then released -> busy=1 for exactly 31 cycles, then 0; every address reads 0.
REQ-035 After sweep: write 0xDEADBEEF to r5; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; raddr_b=0 -> 0.
REQ-036 Write 0x12345678 to r0 -> r0 still reads 0.
REQ-037 Same-cycle write 0xA5A5A5A5 to r7 with raddr_a=7 -> rdata_a=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without it.
REQ-038 clear pulse in READY, then we=1 to r3 with 0x1 on the next cycle -> busy=1, write dropped, r3 reads 0 after the sweep.
REQ-039 reset asserted at sweep index 10 -> counter restarts at 1; busy stays high for 31 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file and its clear sequencer.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer: walks indices 1..NUM_REGS-1 once after reset or a clear request,
// strobing one register per cycle, then settles in READY.
import regfile_pkg::*;

module regfile_clear_seq #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_idx,
  output logic                  clr_stb
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= FIRST_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        if (clear) begin
          w_cnt_nxt = FIRST_IDX;
        end else if (r_cnt == LAST_IDX) begin
          w_state_nxt = READY;
          w_cnt_nxt   = FIRST_IDX;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = FIRST_IDX;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = FIRST_IDX;
      end
    endcase
  end

  always_comb begin
    busy    = (r_state == CLEAR);
    clr_stb = (r_state == CLEAR);
    clr_idx = r_cnt;
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with r0 hardwired to zero and a self-clearing sweep.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports.
import regfile_pkg::*;

module register_file #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_clr_idx;
  logic                  w_clr_stb;
  logic                  w_wr_en;

  regfile_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (w_busy),
    .clr_idx (w_clr_idx),
    .clr_stb (w_clr_stb)
  );

  // A write lands only in READY and loses to reset, clear and the r0 hardwire.
  assign w_wr_en = we && !w_busy && !clear && !reset && (waddr != '0);

  always_ff @(posedge clk) begin
    if (w_clr_stb) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = r_regs[raddr_a];
    rdata_b = r_regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (waddr == raddr_a)) rdata_a = wdata;
    if (w_wr_en && (waddr == raddr_b)) rdata_b = wdata;
`endif
    if (w_busy || (raddr_a == '0)) rdata_a = '0;
    if (w_busy || (raddr_b == '0)) rdata_b = '0;
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected values, a negedge monitor checks them.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int K_BUSY = 0;
  localparam int K_A    = 1;
  localparam int K_B    = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [AW-1:0] raddr_b = '0;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          busy;

  always #5 clk = ~clk;

  register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .busy    (busy)
  );

  typedef struct {
    int            kind;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_val(input int kind, input logic [DW-1:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [DW-1:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_BUSY:  act = {{(DW-1){1'b0}}, busy};
        K_A:     act = rdata_a;
        default: act = rdata_b;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles of an active sweep; optional write attempt at step wr_step which must be dropped.
  task automatic sweep_steps(input int n, input int wr_step, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd);
    for (int i = 0; i < n; i++) begin
      we      = (i == wr_step);
      waddr   = wa;
      wdata   = wd;
      raddr_a = wa;
      raddr_b = AW'(i);
      expect_val(K_BUSY, 32'd1, "busy_sweep");
      expect_val(K_A, 32'd0, "rd_a_busy");
      expect_val(K_B, 32'd0, "rd_b_busy");
      step();
    end
    we = 1'b0;
  endtask

  task automatic write_reg(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    we = 1'b1; waddr = wa; wdata = wd;
    step();
    we = 1'b0;
  endtask

  initial begin
    // Reset held for two edges, then the 31-cycle power-up sweep.
    reset = 1'b1;
    step();
    expect_val(K_BUSY, 32'd1, "busy_in_reset");
    step();
    reset = 1'b0;
    sweep_steps(31, -1, 5'd0, 32'd0);
    expect_val(K_BUSY, 32'd0, "busy_after_sweep");
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_after_sweep_direct: got %b expected 0 at %0t", busy, $time);
    end
    for (int i = 0; i < 32; i++) begin
      raddr_a = AW'(i);
      raddr_b = AW'(31 - i);
      expect_val(K_A, 32'd0, "post_sweep_a");
      expect_val(K_B, 32'd0, "post_sweep_b");
      step();
    end

    // Write r5 and read it back next cycle; r0 on port b.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5; raddr_b = 5'd0;
    expect_val(K_A, BYP ? 32'hDEADBEEF : 32'd0, "r5_write_cycle");
    step();
    we = 1'b0;
    expect_val(K_A, 32'hDEADBEEF, "r5_readback");
    expect_val(K_B, 32'd0, "r0_port_b");
    #1;
    n_checks++;
    if (rdata_a !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL r5_readback_direct: got %h expected deadbeef at %0t", rdata_a, $time);
    end
    n_checks++;
    if (rdata_b !== 32'd0) begin
      n_errors++;
      $display("FAIL r0_port_b_direct: got %h expected 0 at %0t", rdata_b, $time);
    end
    step();

    // Write to r0 is discarded, including on the bypass path.
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr_a = 5'd0; raddr_b = 5'd0;
    expect_val(K_A, 32'd0, "r0_write_cycle_a");
    expect_val(K_B, 32'd0, "r0_write_cycle_b");
    step();
    we = 1'b0;
    expect_val(K_A, 32'd0, "r0_after_write_a");
    expect_val(K_B, 32'd0, "r0_after_write_b");
    step();

    // Same-cycle write/read of r7 over an old value.
    write_reg(5'd7, 32'h11111111);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7; raddr_b = 5'd5;
    expect_val(K_A, BYP ? 32'hA5A5A5A5 : 32'h11111111, "r7_same_cycle");
    expect_val(K_B, 32'hDEADBEEF, "r5_other_port");
    step();
    we = 1'b0; raddr_a = 5'd7; raddr_b = 5'd7;
    expect_val(K_A, 32'hA5A5A5A5, "r7_port_a");
    expect_val(K_B, 32'hA5A5A5A5, "r7_port_b");
    step();

    // clear together with a write: write dropped, sweep starts on the next edge.
    write_reg(5'd3, 32'h33);
    clear = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hBAD; raddr_a = 5'd3; raddr_b = 5'd5;
    expect_val(K_BUSY, 32'd0, "busy_on_clear_cycle");
    expect_val(K_A, 32'h33, "r3_before_clear");
    step();
    clear = 1'b0;
    sweep_steps(1, 0, 5'd3, 32'h1);
    sweep_steps(30, 15, 5'd3, 32'h77);
    raddr_a = 5'd3; raddr_b = 5'd7;
    expect_val(K_BUSY, 32'd0, "busy_after_clear_sweep");
    expect_val(K_A, 32'd0, "r3_after_clear");
    expect_val(K_B, 32'd0, "r7_after_clear");
    step();

    // clear re-asserted mid-sweep restarts the count.
    write_reg(5'd9, 32'h99);
    raddr_a = 5'd9;
    expect_val(K_A, 32'h99, "r9_written");
    clear = 1'b1;
    step();
    clear = 1'b0;
    sweep_steps(15, -1, 5'd9, 32'd0);
    clear = 1'b1;
    expect_val(K_BUSY, 32'd1, "busy_clear_in_clear");
    step();
    clear = 1'b0;
    sweep_steps(31, -1, 5'd9, 32'd0);
    expect_val(K_BUSY, 32'd0, "busy_after_restart");
    step();

    // reset at sweep index 10 restarts the sweep; late write to r9 dropped.
    write_reg(5'd9, 32'h99);
    clear = 1'b1;
    step();
    clear = 1'b0;
    sweep_steps(9, -1, 5'd9, 32'd0);
    reset = 1'b1;
    expect_val(K_BUSY, 32'd1, "busy_at_idx10");
    step();
    reset = 1'b0;
    sweep_steps(31, 20, 5'd9, 32'h55);
    raddr_a = 5'd9; raddr_b = 5'd9;
    expect_val(K_BUSY, 32'd0, "busy_after_reset_sweep");
    expect_val(K_A, 32'd0, "r9_after_reset_a");
    expect_val(K_B, 32'd0, "r9_after_reset_b");
    step();

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
